// File: rtl/mdu_pkg.sv
// Shared encodings and default latencies for the multiply/divide unit.
package mdu_pkg;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;

  localparam int MDU_MULT_CYCLES_DEF = 5;
  localparam int MDU_DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit {hi,lo} result for MULT/MULTU/DIV/DIVU, including
// the zero-divisor flag and the signed-overflow divide case.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] rs_data_i,
  input  logic [31:0] rt_data_i,
  output logic [63:0] result_o,
  output logic        div_by_zero_o
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        dz;
  logic        ovf;
  logic [31:0] divisor;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] uq_s;
  logic [31:0] ur_s;
  logic [31:0] q_s;
  logic [31:0] r_s;
  logic [31:0] q_u;
  logic [31:0] r_u;

  always_comb begin
    // Low 64 bits of the product of sign-extended operands is the signed product.
    prod_s  = {{32{rs_data_i[31]}}, rs_data_i} * {{32{rt_data_i[31]}}, rt_data_i};
    prod_u  = {32'd0, rs_data_i} * {32'd0, rt_data_i};
    dz      = (rt_data_i == 32'd0);
    ovf     = (rs_data_i == 32'h8000_0000) && (rt_data_i == 32'hFFFF_FFFF);
    divisor = dz ? 32'd1 : rt_data_i;
    abs_a   = rs_data_i[31] ? (32'd0 - rs_data_i) : rs_data_i;
    abs_b   = divisor[31] ? (32'd0 - divisor) : divisor;
    uq_s    = abs_a / abs_b;
    ur_s    = abs_a % abs_b;
    // Quotient truncates toward zero; remainder follows the dividend's sign.
    q_s     = (rs_data_i[31] ^ divisor[31]) ? (32'd0 - uq_s) : uq_s;
    r_s     = rs_data_i[31] ? (32'd0 - ur_s) : ur_s;
    if (ovf) begin
      q_s = 32'h8000_0000;
      r_s = 32'd0;
    end
    q_u     = rs_data_i / divisor;
    r_u     = rs_data_i % divisor;

    result_o      = 64'd0;
    div_by_zero_o = 1'b0;
    case (op_i)
      MDU_MULT:  result_o = prod_s;
      MDU_MULTU: result_o = prod_u;
      MDU_DIV: begin
        result_o      = {r_s, q_s};
        div_by_zero_o = dz;
      end
      MDU_DIVU: begin
        result_o      = {r_u, q_u};
        div_by_zero_o = dz;
      end
      default: result_o = 64'd0;
    endcase
  end

endmodule

// File: rtl/mdu_unit.sv
// Multiply/divide unit holding HI/LO; fixed-latency busy period per op class.
// Optional MDU_FLUSH_EN adds a flush input that cancels an in-flight op.
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
`ifdef MDU_FLUSH_EN
  input  logic        flush,
`endif
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  // Handshake: start is accepted only in IDLE (busy=0); while busy=1 any
  // start is dropped, and busy falls on the same edge HI/LO commit.
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   pend_q, pend_d;
  logic          pend_dz_q, pend_dz_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic          busy_q, busy_d;
  logic [63:0]   arith_res;
  logic          arith_dz;
  logic          flush_w;

`ifdef MDU_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  mdu_arith u_arith (
    .op_i          (op),
    .rs_data_i     (rs_data),
    .rt_data_i     (rt_data),
    .result_o      (arith_res),
    .div_by_zero_o (arith_dz)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    pend_dz_d = pend_dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    if (flush_w) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      busy_d    = 1'b0;
      pend_d    = '0;
      pend_dz_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (op == MDU_MULT || op == MDU_MULTU) begin
              state_d   = ST_MUL;
              cnt_d     = CW'(MULT_CYCLES);
              busy_d    = 1'b1;
              pend_d    = arith_res;
              pend_dz_d = arith_dz;
            end else if (op == MDU_DIV || op == MDU_DIVU) begin
              state_d   = ST_DIV;
              cnt_d     = CW'(DIV_CYCLES);
              busy_d    = 1'b1;
              pend_d    = arith_res;
              pend_dz_d = arith_dz;
            end else if (op == MDU_MTHI) begin
              hi_d = rs_data;
            end else if (op == MDU_MTLO) begin
              lo_d = rs_data;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d   = ST_IDLE;
            busy_d    = 1'b0;
            pend_d    = '0;
            pend_dz_d = 1'b0;
            if (!pend_dz_q) begin
              hi_d = pend_q[63:32];
              lo_d = pend_q[31:0];
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pend_q    <= '0;
      pend_dz_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      pend_dz_q <= pend_dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
